// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/rotates, bit-serial shifts,
// shift-add multiply, with a valid/ready request and result handshake.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero
);
  localparam int S = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_ADC = 4'd2,  OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_PASS = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8,  OP_ROR = 4'd9,  OP_RCL = 4'd10, OP_RCR = 4'd11;
  localparam logic [3:0] OP_SHL = 4'd12, OP_SHR = 4'd13, OP_MUL = 4'd14;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] mc, hi, lo;
  logic [S:0]       cnt;

  logic             accept, is_seq, last;
  logic [S-1:0]     amt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx, sh_nx;
  logic             sh_cy;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign amt       = b[S-1:0];
  assign is_seq    = (((opcode == OP_SHL) || (opcode == OP_SHR)) && (amt != '0)) ||
                     (opcode == OP_MUL);
  assign last      = (cnt == (S+1)'(1));

  // Single-cycle operations, evaluated straight from the request inputs
  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    case (opcode)
      OP_ADD:  {alu_cy, alu_res} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {alu_cy, alu_res} = {1'b0, a} - {1'b0, b};
      OP_ADC:  {alu_cy, alu_res} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
      OP_SBB:  {alu_cy, alu_res} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_PASS: begin alu_res = b; alu_cy = carry_in; end
      OP_ROL:  alu_res = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  alu_res = {a[0], a[WIDTH-1:1]};
      OP_RCL:  begin alu_res = {a[WIDTH-2:0], carry_in}; alu_cy = a[WIDTH-1]; end
      OP_RCR:  begin alu_res = {carry_in, a[WIDTH-1:1]}; alu_cy = a[0]; end
      OP_SHL, OP_SHR: alu_res = a;  // zero shift amount only
      default: ;
    endcase
  end

  // One iterative step: {hi,lo} is the multiply accumulator, lo alone the shifter
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
    sh_nx     = (op_q == OP_SHL) ? {lo[WIDTH-2:0], 1'b0} : {1'b0, lo[WIDTH-1:1]};
    sh_cy     = (op_q == OP_SHL) ? lo[WIDTH-1] : lo[0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = is_seq ? BUSY : DONE;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      mc        <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= opcode;
          mc   <= a;
          hi   <= '0;
          if (is_seq) begin
            cnt <= (opcode == OP_MUL) ? (S+1)'(WIDTH) : {1'b0, amt};
            lo  <= (opcode == OP_MUL) ? b : a;
          end else begin
            result    <= alu_res;
            result_hi <= '0;
            carry_out <= alu_cy;
            zero      <= (alu_res == '0);
          end
        end
        BUSY: begin
          cnt <= cnt - (S+1)'(1);
          if (op_q == OP_MUL) begin
            hi <= mul_hi_nx;
            lo <= mul_lo_nx;
            if (last) begin
              result    <= mul_lo_nx;
              result_hi <= mul_hi_nx;
              carry_out <= (mul_hi_nx != '0);
              zero      <= ({mul_hi_nx, mul_lo_nx} == '0);
            end
          end else begin
            lo <= sh_nx;
            if (last) begin
              result    <= sh_nx;
              result_hi <= '0;
              carry_out <= sh_cy;
              zero      <= (sh_nx == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8): directed checks with literal expectations plus
// a long randomized run compared every cycle against a transaction-level model.
module tb_alu_mc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0, carry_in = 1'b0;
  logic [3:0] opcode = '0;
  logic [7:0] a = '0, b = '0;
  logic       in_ready, out_valid, carry_out, zero;
  logic [7:0] result, result_hi;

  int n_cmp = 0, n_bad = 0;

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carry_out(carry_out), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic       co;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a8, input logic [7:0] b8,
                                 input logic ci);
    int x, y, c, n, r, h, co;
    x = a8; y = b8; c = ci; n = b8 % 8; r = 0; h = 0; co = 0;
    case (op)
      0:  begin r = x + y;      co = r >> 8; end
      1:  begin r = x - y;      co = (x < y); end
      2:  begin r = x + y + c;  co = r >> 8; end
      3:  begin r = x - y - c;  co = (x < y + c); end
      4:  r = x & y;
      5:  r = x | y;
      6:  r = x ^ y;
      7:  begin r = y; co = c; end
      8:  r = (x << 1) | (x >> 7);
      9:  r = (x >> 1) | ((x & 1) << 7);
      10: begin r = (x << 1) | c; co = x >> 7; end
      11: begin r = (c << 7) | (x >> 1); co = x & 1; end
      12: begin r = x << n; co = (n != 0) ? ((x >> (8 - n)) & 1) : 0; end
      13: begin r = x >> n; co = (n != 0) ? ((x >> (n - 1)) & 1) : 0; end
      14: begin r = x * y; h = (x * y) >> 8; co = (h != 0); end
      default: ;
    endcase
    return '{res: 8'(r & 255), hi: 8'(h & 255), co: (co != 0)};
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [7:0] b8);
    if (op == 14) return 9;
    if (op == 12 || op == 13) return (b8 % 8) + 1;
    return 1;
  endfunction

  // Transaction model: 0 idle, 1 working, 2 result presented
  int   m_phase = 0;
  int   m_left  = 0;
  logic m_clear = 1'b1;
  exp_t m_pend  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_clear <= 1'b1;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_pend  <= model(opcode, a, b, carry_in);
          m_left  <= lat_of(opcode, b) - 1;
          m_phase <= (lat_of(opcode, b) == 1) ? 2 : 1;
          if (lat_of(opcode, b) == 1) m_clear <= 1'b0;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin m_phase <= 2; m_clear <= 1'b0; end
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
    chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
    if (m_phase == 2 || m_clear) begin
      chk("result",    32'(result),    m_clear ? 32'd0 : 32'(m_pend.res));
      chk("result_hi", 32'(result_hi), m_clear ? 32'd0 : 32'(m_pend.hi));
      chk("carry_out", 32'(carry_out), m_clear ? 32'd0 : 32'(m_pend.co));
      chk("zero",      32'(zero),      m_clear ? 32'd0 : 32'(m_pend.res == 0 && m_pend.hi == 0));
    end
  end

  // Issue one request from idle, scramble inputs after accept, and wait for the
  // result; lat counts cycles from accept to out_valid, busy_rdy flags any in_ready.
  task automatic run(input logic [3:0] op, input logic [7:0] ra, input logic [7:0] rb,
                     input logic rci, output int lat, output logic busy_rdy);
    @(negedge clk);
    opcode = op; a = ra; b = rb; carry_in = rci; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    opcode = 4'($urandom); a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
    lat = 1; busy_rdy = 1'b0;
    while (!out_valid && lat < 100) begin
      busy_rdy |= in_ready;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_res();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_release_ready", 32'(in_ready), 32'd1);
    chk("idle_after_release_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic br;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'({result_hi, result}), 32'd0);
    chk("rst_flags", 32'({carry_out, zero}), 32'd0);

    run(4'd0, 8'hFF, 8'h01, 1'b0, lat, br);
    chk("add_lat", 32'(lat), 32'd1);
    chk("add_res", 32'({result, carry_out, zero}), 32'({8'h00, 1'b1, 1'b1}));
    release_res();

    run(4'd3, 8'h05, 8'h05, 1'b1, lat, br);
    chk("sbb_res", 32'({result, carry_out, zero}), 32'({8'hFF, 1'b1, 1'b0}));
    release_res();

    run(4'd14, 8'hFF, 8'hFF, 1'b0, lat, br);
    chk("mul_lat", 32'(lat), 32'd9);
    chk("mul_res", 32'({result_hi, result, carry_out}), 32'({8'hFE, 8'h01, 1'b1}));
    chk("mul_busy_ready", 32'(br), 32'd0);
    release_res();

    run(4'd12, 8'h81, 8'd3, 1'b0, lat, br);
    chk("shl_lat", 32'(lat), 32'd4);
    chk("shl_res", 32'({result, carry_out}), 32'({8'h08, 1'b0}));
    release_res();

    run(4'd13, 8'h81, 8'd0, 1'b1, lat, br);
    chk("shr0_lat", 32'(lat), 32'd1);
    chk("shr0_res", 32'({result, carry_out}), 32'({8'h81, 1'b0}));
    release_res();

    run(4'd13, 8'h81, 8'd7, 1'b0, lat, br);
    chk("shr7_res", 32'({result, carry_out, zero}), 32'({8'h01, 1'b0, 1'b0}));
    release_res();

    // Result must hold through a stalled consumer while new requests are offered
    run(4'd0, 8'h70, 8'h90, 1'b0, lat, br);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; opcode = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    chk("hold_res", 32'({result, carry_out, zero}), 32'({8'h00, 1'b1, 1'b1}));
    release_res();

    // Reset in the third BUSY cycle of a multiply
    @(negedge clk);
    opcode = 4'd14; a = 8'h12; b = 8'h34; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_result", 32'(result), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    run(4'd0, 8'h02, 8'h03, 1'b0, lat, br);
    chk("post_rst_add", 32'({result, carry_out}), 32'({8'h05, 1'b0}));
    release_res();

    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = 1'($urandom);
      opcode    = 4'($urandom);
      a         = 8'($urandom);
      b         = 8'($urandom);
      carry_in  = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
